// File: rtl/tmp_sensor_i2c_slave.sv
// I2C slave front end for a temperature sensor. Exposes a small register
// map (temperature MSB/LSB, configuration, device ID) behind an 8-bit
// auto-incrementing pointer. SDA is open drain: sda_oe = 1 pulls it low.
module tmp_sensor_i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h4B,
    parameter logic [7:0] DEV_ID     = 8'hCB
) (
    input  logic        CLK100MHZ,
    input  logic        reset,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe,
    input  logic [15:0] temp_value,
    output logic [7:0]  cfg_reg,
    output logic        busy,
    output logic        rd_done
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  scl_sync_q, scl_sync_d;   // [1:0] synchroniser, [2] previous synced value
    logic [2:0]  sda_sync_q, sda_sync_d;
    logic        scl_s, scl_p, sda_s, sda_p;
    logic        scl_rise, scl_fall, start_det, stop_det;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;         // incoming byte
    logic [7:0]  tx_q, tx_d;               // outgoing byte, current bit in [7]
    logic [7:0]  ptr_q, ptr_d;
    logic [7:0]  cfg_q, cfg_d;
    logic [15:0] snap_q, snap_d;           // temperature frozen for one read transaction
    logic        sda_oe_q, sda_oe_d;
    logic        busy_q, busy_d;
    logic        rd_done_q, rd_done_d;
    logic        phase_q, phase_d;         // second half of an ACK slot
    logic        first_q, first_d;         // next written byte is the pointer
    logic        rw_q, rw_d;
    logic [7:0]  rx_byte, rd_byte;

    function automatic logic [7:0] reg_read(input logic [7:0] ptr, input logic [15:0] snap,
                                            input logic [7:0] cfg);
        case (ptr)
            8'h00:   return snap[15:8];
            8'h01:   return snap[7:0];
            8'h03:   return cfg;
            8'h0B:   return DEV_ID;
            default: return 8'h00;
        endcase
    endfunction

    assign scl_s     = scl_sync_q[1];
    assign scl_p     = scl_sync_q[2];
    assign sda_s     = sda_sync_q[1];
    assign sda_p     = sda_sync_q[2];
    assign scl_rise  = scl_s & ~scl_p;
    assign scl_fall  = ~scl_s & scl_p;
    assign start_det = scl_s & scl_p & sda_p & ~sda_s;
    assign stop_det  = scl_s & scl_p & ~sda_p & sda_s;

    assign sda_oe  = sda_oe_q;
    assign cfg_reg = cfg_q;
    assign busy    = busy_q;
    assign rd_done = rd_done_q;

    // Next-state, bus drive and register updates from synchronised SCL/SDA events.
    always_comb begin
        // NOTE: every _d takes its current value first, so no path through this block can infer a latch.
        state_d    = state_q;
        scl_sync_d = {scl_sync_q[1:0], scl_in};
        sda_sync_d = {sda_sync_q[1:0], sda_in};
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        ptr_d      = ptr_q;
        cfg_d      = cfg_q;
        snap_d     = snap_q;
        sda_oe_d   = sda_oe_q;
        busy_d     = busy_q;
        rd_done_d  = 1'b0;
        phase_d    = phase_q;
        first_d    = first_q;
        rw_d       = rw_q;
        rx_byte    = {shift_q[6:0], sda_s};
        // A fresh read byte comes straight from the live input when the snapshot is taken.
        rd_byte    = reg_read(ptr_q, (state_q == ADDR_ACK) ? temp_value : snap_q, cfg_q);

        if (stop_det) begin
            state_d  = IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (start_det) begin
            state_d   = ADDR;
            sda_oe_d  = 1'b0;
            bit_cnt_d = 4'd0;
            shift_d   = 8'h00;
            phase_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: ;
                ADDR: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = 4'd0;
                            phase_d   = 1'b0;
                            if (rx_byte[7:1] == SLAVE_ADDR) begin
                                state_d = ADDR_ACK;
                                rw_d    = rx_byte[0];
                                busy_d  = 1'b1;
                            end else begin
                                state_d = WAIT_STOP;
                                busy_d  = 1'b0;
                            end
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!phase_q) begin
                            sda_oe_d = 1'b1;
                            phase_d  = 1'b1;
                        end else begin
                            phase_d   = 1'b0;
                            bit_cnt_d = 4'd0;
                            if (rw_q) begin
                                state_d  = RD_BYTE;
                                snap_d   = temp_value;
                                tx_d     = rd_byte;
                                sda_oe_d = ~rd_byte[7];
                            end else begin
                                state_d  = WR_BYTE;
                                first_d  = 1'b1;
                                sda_oe_d = 1'b0;
                            end
                        end
                    end
                end
                WR_BYTE: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = 4'd0;
                            phase_d   = 1'b0;
                            state_d   = WR_ACK;
                            if (first_q) begin
                                ptr_d   = rx_byte;
                                first_d = 1'b0;
                            end else begin
                                if (ptr_q == 8'h03) cfg_d = rx_byte;
                                ptr_d = ptr_q + 8'd1;
                            end
                        end
                    end
                end
                WR_ACK: begin
                    if (scl_fall) begin
                        if (!phase_q) begin
                            sda_oe_d = 1'b1;
                            phase_d  = 1'b1;
                        end else begin
                            sda_oe_d = 1'b0;
                            phase_d  = 1'b0;
                            state_d  = WR_BYTE;
                        end
                    end
                end
                RD_BYTE: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            state_d   = RD_ACK;
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 4'd0;
                            phase_d   = 1'b0;
                        end else begin
                            tx_d     = {tx_q[6:0], 1'b0};
                            sda_oe_d = ~tx_q[6];
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        rd_done_d = 1'b1;
                        ptr_d     = ptr_q + 8'd1;
                        if (sda_s) state_d = WAIT_STOP;
                        else       phase_d = 1'b1;
                    end else if (scl_fall && phase_q) begin
                        state_d   = RD_BYTE;
                        phase_d   = 1'b0;
                        bit_cnt_d = 4'd0;
                        tx_d      = rd_byte;
                        sda_oe_d  = ~rd_byte[7];
                    end
                end
                WAIT_STOP: sda_oe_d = 1'b0;
                default:   state_d  = IDLE;
            endcase
        end
    end

    // State register with synchronous reset; synchronisers idle high like the bus.
    always_ff @(posedge CLK100MHZ) begin
        // NOTE: non-blocking assignments so every flop samples values from before this edge.
        if (reset) begin
            state_q    <= IDLE;
            scl_sync_q <= 3'b111;
            sda_sync_q <= 3'b111;
            bit_cnt_q  <= 4'd0;
            shift_q    <= 8'h00;
            tx_q       <= 8'h00;
            ptr_q      <= 8'h00;
            cfg_q      <= 8'h00;
            snap_q     <= 16'h0000;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            rd_done_q  <= 1'b0;
            phase_q    <= 1'b0;
            first_q    <= 1'b0;
            rw_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            ptr_q      <= ptr_d;
            cfg_q      <= cfg_d;
            snap_q     <= snap_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
            rd_done_q  <= rd_done_d;
            phase_q    <= phase_d;
            first_q    <= first_d;
            rw_q       <= rw_d;
        end
    end

endmodule
